instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Multi-cycle instruction sequencer that drives the ALU/register-file datapath. It fetches 32-bit instructions from instruction memory over a req/ack handshake and holds each one in an instruction register. It decodes Opcode/Funct into ALU_op, ALU_src, Reg_write and Writeback_src, then steps each instruction through DECODE, EXECUTE and WRITEBACK. It owns the PC, gates register writes to exactly one cycle per instruction, and stops on a HALT opcode.

## Interface
Parameters:
- PC_W, 8: PC and instruction-memory address width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Run  in  1  start/continue enable, sampled in IDLE and at the end of WRITEBACK.
- Imem_req  out  1  fetch request.
- Imem_addr  out  PC_W  fetch address; equals PC while Imem_req=1.
- Imem_ack  in  1  memory has Imem_rdata valid this cycle.
- Imem_rdata  in  32  fetched instruction.
- Instr  out  32  instruction register; Opcode=Instr[31:26], Funct=Instr[5:0].
- ALU_op  out  1  ALU operation select.
- ALU_src  out  1  ALU operand-B select.
- Reg_write  out  1  register-file write enable.
- Writeback_src  out  1  writeback mux select.
- Retired  out  1  one-cycle pulse per completed instruction.
- Halted  out  1  high while in HALT.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, HALT.
- Reset: state IDLE, PC=RESET_PC. Instr, Imem_req, ALU_op, ALU_src, Reg_write, Writeback_src, Retired and Halted are all 0.
- IDLE:
  - Run=1 moves to FETCH.
  - All outputs hold, except that Reg_write and Retired are 0.
- FETCH:
  - Imem_req=1 and Imem_addr=PC, held stable until Imem_ack=1 is sampled.
  - On ack, Instr<=Imem_rdata, next state is DECODE, and Imem_req=0 from the next cycle.
  - Imem_ack outside FETCH is ignored.
- DECODE: registers the control outputs from Instr.
  - Opcode 000000: ALU_op=0, ALU_src=~Funct[5], Writeback_src=0, write-type.
  - Opcode 111111: ALU_op=1, ALU_src=0, Writeback_src=1, write-type.
  - Opcode 111110 (HALT): next state is HALT. Control outputs become ALU_op=1 and 0 for the others.
  - Any other opcode is a NOP: ALU_op=1, ALU_src=0, Writeback_src=0, not write-type.
- EXECUTE: one cycle, Reg_write=0, control outputs stable.
- WRITEBACK: one cycle.
  - Reg_write=1 only if write-type.
  - Retired=1.
  - PC<=PC+1, wrapping modulo 2^PC_W (all-ones wraps to 0).
  - Next state is FETCH if Run=1, otherwise IDLE.
- Run dropping mid-instruction does not abort it. The current instruction completes, then the block goes to IDLE.
- HALT: Halted=1, Reg_write=0, no fetches. Only rst exits; Run is ignored.
- rst in any state, including mid-FETCH with Imem_req=1, wins. Next cycle is IDLE with reset values, and a late ack is ignored.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Per-instruction latency is (cycles in FETCH) + 3. With a same-cycle ack the sequence is FETCH, DECODE, EXECUTE, WRITEBACK: 4 cycles per instruction.
- ALU_op, ALU_src and Writeback_src are valid from the cycle after DECODE and hold until the next DECODE updates them. They are therefore stable across EXECUTE and WRITEBACK.
- Reg_write and Retired are high for exactly 1 cycle per write-type or any instruction, respectively. They are never high in the same cycle as Imem_req.
- Memory may hold Imem_ack low indefinitely; the sequencer waits with no timeout.

## Structure
- Package seq_pkg holds:
  - the state enum;
  - opcode constants OP_RTYPE=6'b000000, OP_ALT=6'b111111, OP_HALT=6'b111110;
  - the field position constants for Opcode and Funct.
- Sub-module seq_decode: a combinational Opcode/Funct to {ALU_op, ALU_src, Writeback_src, is_write, is_halt} decoder, registered by the parent in DECODE.
- Target size is 150–250 lines of RTL.

## Test plan
- Reset then Run=1, ack on the same cycle, Instr=0x00000020 at PC 0. Expect 4 cycles, ALU_op=0, ALU_src=0, Writeback_src=0, one Reg_write pulse, Retired pulse, PC=1.
- Opcode 111111 fetched with ack delayed 3 cycles. Expect Imem_req/addr stable for 4 cycles, ALU_op=1, Writeback_src=1, Reg_write one pulse, 7-cycle instruction.
- Opcode 000000 with Funct=0x05. Expect ALU_src=1. Then opcode 001000 (NOP): Retired pulses, Reg_write stays 0.
- PC_W=8, PC=0xFF, any instruction. Expect PC=0x00 after WRITEBACK and next Imem_addr=0x00.
- Run deasserted during EXECUTE. Expect WRITEBACK to complete, then IDLE with no new Imem_req. Run reasserted: fetch resumes at PC+1.
- Two cases:
  - HALT opcode: expect Halted=1 and no Imem_req for 20 cycles even with Run=1.
  - rst mid-FETCH: expect Imem_req=0 next cycle, PC=RESET_PC, and a late Imem_ack ignored.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer.
package seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXECUTE,
      S_WRITEBACK,
      S_HALT
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ALT   = 6'b111111;
   localparam logic [5:0] OP_HALT  = 6'b111110;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 26;
   localparam int FN_MSB  = 5;
   localparam int FN_LSB  = 0;

   // Decoded control bundle; is_write/is_halt steer the FSM, the rest drive the datapath.
   typedef struct packed {
      logic alu_op;
      logic alu_src;
      logic wb_src;
      logic is_write;
      logic is_halt;
   } ctrl_t;

   function automatic logic [5:0] opcode_of(input logic [31:0] instr);
      return instr[OPC_MSB:OPC_LSB];
   endfunction

   function automatic logic [5:0] funct_of(input logic [31:0] instr);
      return instr[FN_MSB:FN_LSB];
   endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational Opcode/Funct decoder; the parent registers its result in DECODE.
module seq_decode
   import seq_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output ctrl_t      ctrl
);

   // Only Funct[5] steers operand B; the low bits are reserved for the ALU itself.
   logic unused_funct;
   assign unused_funct = ^funct[4:0];

   // Map the opcode to control bits; unknown opcodes retire as NOPs.
   always_comb begin
      ctrl = '{alu_op: 1'b1, alu_src: 1'b0, wb_src: 1'b0, is_write: 1'b0, is_halt: 1'b0};
      case (opcode)
         OP_RTYPE: begin
            ctrl.alu_op   = 1'b0;
            ctrl.alu_src  = ~funct[5];
            ctrl.is_write = 1'b1;
         end
         OP_ALT: begin
            ctrl.wb_src   = 1'b1;
            ctrl.is_write = 1'b1;
         end
         OP_HALT: begin
            ctrl.is_halt  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle FETCH/DECODE/EXECUTE/WRITEBACK sequencer; every output is a register
// that is loaded on the edge entering the state it belongs to.
module instr_sequencer
   import seq_pkg::*;
#(
   parameter int unsigned     PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            Run,
   output logic            Imem_req,
   output logic [PC_W-1:0] Imem_addr,
   input  logic            Imem_ack,
   input  logic [31:0]     Imem_rdata,
   output logic [31:0]     Instr,
   output logic            ALU_op,
   output logic            ALU_src,
   output logic            Reg_write,
   output logic            Writeback_src,
   output logic            Retired,
   output logic            Halted
);

   state_t          state;
   logic [PC_W-1:0] pc;
   logic            is_write_q;
   ctrl_t           dec;

   seq_decode u_decode (
      .opcode (opcode_of(Instr)),
      .funct  (funct_of(Instr)),
      .ctrl   (dec)
   );

   // PC only moves at the end of WRITEBACK, so it is stable for the whole fetch.
   assign Imem_addr = pc;

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= S_IDLE;
         pc            <= RESET_PC;
         Instr         <= '0;
         Imem_req      <= 1'b0;
         ALU_op        <= 1'b0;
         ALU_src       <= 1'b0;
         Writeback_src <= 1'b0;
         Reg_write     <= 1'b0;
         Retired       <= 1'b0;
         Halted        <= 1'b0;
         is_write_q    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               Reg_write <= 1'b0;
               Retired   <= 1'b0;
               if (Run) begin
                  state    <= S_FETCH;
                  Imem_req <= 1'b1;
               end
            end
            S_FETCH: begin
               // Request stays up with a fixed address until the memory answers.
               if (Imem_ack) begin
                  Instr    <= Imem_rdata;
                  Imem_req <= 1'b0;
                  state    <= S_DECODE;
               end
            end
            S_DECODE: begin
               ALU_op        <= dec.alu_op;
               ALU_src       <= dec.alu_src;
               Writeback_src <= dec.wb_src;
               is_write_q    <= dec.is_write;
               if (dec.is_halt) begin
                  state  <= S_HALT;
                  Halted <= 1'b1;
               end else begin
                  state  <= S_EXECUTE;
               end
            end
            S_EXECUTE: begin
               // Raise the single-cycle write/retire strobes for WRITEBACK.
               Reg_write <= is_write_q;
               Retired   <= 1'b1;
               state     <= S_WRITEBACK;
            end
            S_WRITEBACK: begin
               Reg_write <= 1'b0;
               Retired   <= 1'b0;
               pc        <= pc + PC_W'(1);
               if (Run) begin
                  state    <= S_FETCH;
                  Imem_req <= 1'b1;
               end else begin
                  state    <= S_IDLE;
               end
            end
            S_HALT: begin
               // Terminal until reset; Run is ignored here.
               Halted    <= 1'b1;
               Reg_write <= 1'b0;
               Retired   <= 1'b0;
               Imem_req  <= 1'b0;
            end
            default: begin
               state    <= S_IDLE;
               Imem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer with a small instruction-memory responder.
module tb_instr_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        Run;
   logic        Imem_req;
   logic [7:0]  Imem_addr;
   logic        Imem_ack;
   logic [31:0] Imem_rdata;
   logic [31:0] Instr;
   logic        ALU_op, ALU_src, Reg_write, Writeback_src, Retired, Halted;

   int n_vec  = 0;
   int n_miss = 0;

   logic [31:0] mem [256];
   logic        stall     = 1'b0;
   logic        force_ack = 1'b0;

   localparam logic [31:0] I_R20  = 32'h0000_0020;
   localparam logic [31:0] I_ALT  = 32'hFC00_0000;
   localparam logic [31:0] I_R05  = 32'h0000_0005;
   localparam logic [31:0] I_NOP  = 32'h2000_0000;
   localparam logic [31:0] I_HALT = 32'hF800_0000;

   instr_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
      .clk           (clk),
      .rst           (rst),
      .Run           (Run),
      .Imem_req      (Imem_req),
      .Imem_addr     (Imem_addr),
      .Imem_ack      (Imem_ack),
      .Imem_rdata    (Imem_rdata),
      .Instr         (Instr),
      .ALU_op        (ALU_op),
      .ALU_src       (ALU_src),
      .Reg_write     (Reg_write),
      .Writeback_src (Writeback_src),
      .Retired       (Retired),
      .Halted        (Halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Memory responder: acks after a per-address wait (3 extra cycles at address 1).
   initial begin
      int cnt = 0;
      Imem_ack   = 1'b0;
      Imem_rdata = '0;
      forever begin
         @(negedge clk);
         if (force_ack) begin
            Imem_ack   = 1'b1;
            Imem_rdata = 32'hDEAD_BEEF;
         end else if (Imem_req && !stall) begin
            if (cnt >= ((Imem_addr == 8'd1) ? 3 : 0)) begin
               Imem_ack   = 1'b1;
               Imem_rdata = mem[Imem_addr];
               cnt        = 0;
            end else begin
               Imem_ack   = 1'b0;
               cnt++;
            end
         end else begin
            Imem_ack   = 1'b0;
            Imem_rdata = '0;
            cnt        = 0;
         end
      end
   end

   // Runs one instruction starting in its first FETCH cycle; returns in WRITEBACK.
   task automatic run_one(output int cyc, output int nrw, output int nreq, output logic addr_ok);
      logic [7:0] a0;
      a0 = Imem_addr;
      cyc = 0; nrw = 0; nreq = 0; addr_ok = 1'b1;
      forever begin
         cyc++;
         if (Imem_req) begin
            nreq++;
            if (Imem_addr !== a0) addr_ok = 1'b0;
         end
         if (Reg_write) nrw++;
         if (Reg_write && Imem_req) addr_ok = 1'b0;
         if (Retired || cyc > 50) break;
         tick(1);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc, nrw, nreq, cnt, g;
      logic aok;

      for (int i = 0; i < 256; i++) mem[i] = I_NOP;
      mem[0] = I_R20; mem[1] = I_ALT; mem[2] = I_R05; mem[3] = I_NOP; mem[4] = I_R20;

      rst = 1'b1; Run = 1'b0;
      tick(2);
      rst = 1'b0;
      tick(1);
      chk("rst_req",    Imem_req, 0);
      chk("rst_addr",   Imem_addr, 0);
      chk("rst_instr",  Instr, 0);
      chk("rst_ctrl",   {ALU_op, ALU_src, Writeback_src}, 0);
      chk("rst_strobe", {Reg_write, Retired, Halted}, 0);

      // R-type funct 0x20, same-cycle ack
      Run = 1'b1;
      tick(1);
      chk("i0_req", Imem_req, 1);
      run_one(cyc, nrw, nreq, aok);
      chk("i0_cyc",   cyc, 4);
      chk("i0_nrw",   nrw, 1);
      chk("i0_instr", Instr, I_R20);
      chk("i0_ctrl",  {ALU_op, ALU_src, Writeback_src}, 3'b000);
      tick(1);
      chk("i1_addr", Imem_addr, 1);

      // Opcode 111111 with ack delayed 3 cycles
      run_one(cyc, nrw, nreq, aok);
      chk("i1_cyc",  cyc, 7);
      chk("i1_nreq", nreq, 4);
      chk("i1_stab", aok, 1);
      chk("i1_nrw",  nrw, 1);
      chk("i1_ctrl", {ALU_op, ALU_src, Writeback_src}, 3'b101);
      tick(1);

      // R-type funct 0x05 -> operand B select set
      run_one(cyc, nrw, nreq, aok);
      chk("i2_ctrl", {ALU_op, ALU_src, Writeback_src}, 3'b010);
      chk("i2_nrw",  nrw, 1);
      tick(1);

      // NOP opcode 001000
      run_one(cyc, nrw, nreq, aok);
      chk("i3_cyc",  cyc, 4);
      chk("i3_nrw",  nrw, 0);
      chk("i3_ctrl", {ALU_op, ALU_src, Writeback_src}, 3'b100);
      tick(1);

      // Run dropped during EXECUTE: finish, then idle
      chk("i4_addr", Imem_addr, 4);
      tick(2);
      Run = 1'b0;
      tick(1);
      chk("i4_wb", {Retired, Reg_write}, 2'b11);
      cnt = 0;
      for (int i = 0; i < 5; i++) begin
         tick(1);
         if (Imem_req || Retired || Reg_write) cnt++;
      end
      chk("idle_quiet", cnt, 0);
      Run = 1'b1;
      tick(1);
      chk("resume_req",  Imem_req, 1);
      chk("resume_addr", Imem_addr, 5);

      // Reset during a stalled fetch; a late ack must be ignored
      stall = 1'b1;
      tick(2);
      chk("stall_req", {Imem_req, Imem_addr}, {1'b1, 8'd5});
      rst = 1'b1;
      tick(1);
      rst = 1'b0; Run = 1'b0; stall = 1'b0; force_ack = 1'b1;
      chk("mrst_req",  Imem_req, 0);
      chk("mrst_addr", Imem_addr, 0);
      chk("mrst_ctrl", {ALU_op, ALU_src, Writeback_src}, 0);
      tick(3);
      force_ack = 1'b0;
      chk("late_ack_instr", Instr, 0);
      chk("late_ack_req",   Imem_req, 0);

      // PC wrap from 0xFF to 0x00
      Run = 1'b1;
      tick(1);
      g = 0;
      while (Imem_addr !== 8'hFF && g < 300) begin
         run_one(cyc, nrw, nreq, aok);
         tick(1);
         g++;
      end
      chk("wrap_reach", Imem_addr, 8'hFF);
      mem[0] = I_HALT;
      run_one(cyc, nrw, nreq, aok);
      chk("wrap_ret", Retired, 1);
      tick(1);
      chk("wrap_addr", {Imem_req, Imem_addr}, {1'b1, 8'h00});

      // HALT: stays put with Run high
      tick(2);
      chk("halt_flag", Halted, 1);
      chk("halt_ctrl", {ALU_op, ALU_src, Writeback_src}, 3'b100);
      cnt = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (Imem_req || Reg_write || Retired || !Halted) cnt++;
      end
      chk("halt_quiet", cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
